// File: rtl/sda_kernel_ctrl_regs.sv
// sda_kernel_ctrl_regs
//   AXI-Lite control register slave that launches one kernel action through
//   the four-phase go/done handshake pair, holds the param_buf_base pointer
//   for the action and raises a level done interrupt.
// Ports
//   clk, reset          : clock, asynchronous active-low reset
//   s_axi_aw*/w*/b*     : AXI-Lite write address/data/response channels
//   s_axi_ar*/r*        : AXI-Lite read address/data channels
//   go_0r / go_0a       : action start request (out) / ack (in)
//   done_0r / done_0a   : action completion request (in) / ack (out)
//   param_buf_base      : 64-bit parameter buffer pointer to the action
//   interrupt           : GIE & IER[0] & ISR[0]
// Register map (byte address, bits [5:2] decoded)
//   0x00 CTRL  b0 ap_start (W1S) b1 ap_done (RO, clear-on-read) b2 ap_idle
//   0x04 GIE   0x08 IER   0x0C ISR (W1C)   0x10 PARAM_LO   0x14 PARAM_HI
module sda_kernel_ctrl_regs #(
  parameter int unsigned ADDR_WIDTH  = 6,
  parameter logic [63:0] PARAM_RESET = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [31:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic        go_0r,
  input  logic        go_0a,
  input  logic        done_0r,
  output logic        done_0a,
  output logic [63:0] param_buf_base,
  output logic        interrupt
);
  localparam int unsigned IW = ADDR_WIDTH - 2;
  localparam logic [IW-1:0] A_CTRL = IW'(0);
  localparam logic [IW-1:0] A_GIE  = IW'(1);
  localparam logic [IW-1:0] A_IER  = IW'(2);
  localparam logic [IW-1:0] A_ISR  = IW'(3);
  localparam logic [IW-1:0] A_PLO  = IW'(4);
  localparam logic [IW-1:0] A_PHI  = IW'(5);

  typedef enum logic [2:0] {S_IDLE, S_GO_REQ, S_GO_RTZ, S_RUN, S_DONE_ACK} state_t;
  state_t r_state, w_state_nxt;

  logic          r_awready, r_aw_done, r_wready, r_w_done, r_bvalid;
  logic [IW-1:0] r_awaddr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_wstrb;
  logic          r_arready, r_rvalid, r_rd_ctrl;
  logic [31:0]   r_rdata;
  logic          r_gie, r_ier, r_isr, r_ap_done;
  logic          r_start_pend, r_start_go;
  logic [63:0]   r_param;

  logic          w_commit, w_idle, w_done_set, w_rd_hs, w_start;
  logic          w_wr_ctrl, w_wr_gie, w_wr_ier, w_wr_isr, w_wr_plo, w_wr_phi;
  logic [IW-1:0] w_rd_idx;
  logic [31:0]   w_rdata_nxt;
  logic          w_go_0r, w_done_0a;
  logic          w_unused_ok;

  assign w_unused_ok = ^{s_axi_awaddr[31:ADDR_WIDTH], s_axi_awaddr[1:0],
                         s_axi_araddr[31:ADDR_WIDTH], s_axi_araddr[1:0]};

  // A start stays "busy" through its two pipeline stages so that a start or
  // PARAM write landing before GO_REQ is treated like one during the action.
  assign w_idle     = (r_state == S_IDLE) && !r_start_pend && !r_start_go;
  assign w_commit   = r_aw_done && r_w_done && !r_bvalid;
  assign w_done_set = (r_state == S_DONE_ACK) && !done_0r;
  assign w_rd_hs    = r_rvalid && s_axi_rready;
  assign w_wr_ctrl  = w_commit && (r_awaddr == A_CTRL);
  assign w_wr_gie   = w_commit && (r_awaddr == A_GIE) && r_wstrb[0];
  assign w_wr_ier   = w_commit && (r_awaddr == A_IER) && r_wstrb[0];
  assign w_wr_isr   = w_commit && (r_awaddr == A_ISR) && r_wstrb[0];
  assign w_wr_plo   = w_commit && (r_awaddr == A_PLO) && w_idle;
  assign w_wr_phi   = w_commit && (r_awaddr == A_PHI) && w_idle;
  assign w_start    = w_wr_ctrl && r_wstrb[0] && r_wdata[0] && w_idle;

  // Write channel: AW and W captured independently, one response in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_awready <= 1'b0;
      r_aw_done <= 1'b0;
      r_awaddr  <= '0;
      r_wready  <= 1'b0;
      r_w_done  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
    end else begin
      r_awready <= s_axi_awvalid && !r_awready && !r_aw_done && !r_bvalid;
      r_wready  <= s_axi_wvalid && !r_wready && !r_w_done && !r_bvalid;
      if (s_axi_awvalid && r_awready) begin
        r_aw_done <= 1'b1;
        r_awaddr  <= s_axi_awaddr[ADDR_WIDTH-1:2];
      end else if (w_commit) begin
        r_aw_done <= 1'b0;
      end
      if (s_axi_wvalid && r_wready) begin
        r_w_done <= 1'b1;
        r_wdata  <= s_axi_wdata;
        r_wstrb  <= s_axi_wstrb;
      end else if (w_commit) begin
        r_w_done <= 1'b0;
      end
      if (w_commit)                        r_bvalid <= 1'b1;
      else if (r_bvalid && s_axi_bready)   r_bvalid <= 1'b0;
    end
  end

  // Register file; done/ISR set takes priority over clear-on-read and W1C.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gie        <= 1'b0;
      r_ier        <= 1'b0;
      r_isr        <= 1'b0;
      r_ap_done    <= 1'b0;
      r_start_pend <= 1'b0;
      r_start_go   <= 1'b0;
      r_param      <= PARAM_RESET;
    end else begin
      r_start_pend <= w_start;
      r_start_go   <= r_start_pend;
      if (w_wr_gie) r_gie <= r_wdata[0];
      if (w_wr_ier) r_ier <= r_wdata[0];
      if (w_done_set)                    r_isr <= 1'b1;
      else if (w_wr_isr && r_wdata[0])   r_isr <= 1'b0;
      if (w_done_set)                    r_ap_done <= 1'b1;
      else if (w_rd_hs && r_rd_ctrl)     r_ap_done <= 1'b0;
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_wr_plo && r_wstrb[b]) r_param[8*b +: 8]      <= r_wdata[8*b +: 8];
        if (w_wr_phi && r_wstrb[b]) r_param[32+8*b +: 8]   <= r_wdata[8*b +: 8];
      end
    end
  end

  // Read channel
  assign w_rd_idx = s_axi_araddr[ADDR_WIDTH-1:2];

  always_comb begin
    w_rdata_nxt = '0;
    case (w_rd_idx)
      A_CTRL:  w_rdata_nxt = {29'b0, w_idle, r_ap_done, !w_idle};
      A_GIE:   w_rdata_nxt = {31'b0, r_gie};
      A_IER:   w_rdata_nxt = {31'b0, r_ier};
      A_ISR:   w_rdata_nxt = {31'b0, r_isr};
      A_PLO:   w_rdata_nxt = r_param[31:0];
      A_PHI:   w_rdata_nxt = r_param[63:32];
      default: w_rdata_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rd_ctrl <= 1'b0;
    end else begin
      r_arready <= s_axi_arvalid && !r_arready && !r_rvalid;
      if (s_axi_arvalid && r_arready) begin
        r_rvalid  <= 1'b1;
        r_rdata   <= w_rdata_nxt;
        r_rd_ctrl <= (w_rd_idx == A_CTRL);
      end else if (w_rd_hs) begin
        r_rvalid  <= 1'b0;
      end
    end
  end

  // Action FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_go_0r     = 1'b0;
    w_done_0a   = 1'b0;
    case (r_state)
      S_IDLE:     if (r_start_go) w_state_nxt = S_GO_REQ;
      S_GO_REQ: begin
        w_go_0r = 1'b1;
        if (go_0a) w_state_nxt = S_GO_RTZ;
      end
      S_GO_RTZ:   if (!go_0a) w_state_nxt = S_RUN;
      S_RUN:      if (done_0r) w_state_nxt = S_DONE_ACK;
      S_DONE_ACK: begin
        w_done_0a = 1'b1;
        if (!done_0r) w_state_nxt = S_IDLE;
      end
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  assign s_axi_awready  = r_awready;
  assign s_axi_wready   = r_wready;
  assign s_axi_bvalid   = r_bvalid;
  assign s_axi_bresp    = 2'b00;
  assign s_axi_arready  = r_arready;
  assign s_axi_rvalid   = r_rvalid;
  assign s_axi_rdata    = r_rdata;
  assign s_axi_rresp    = 2'b00;
  assign go_0r          = w_go_0r;
  assign done_0a        = w_done_0a;
  assign param_buf_base = r_param;
  assign interrupt      = r_gie && r_ier && r_isr;
endmodule

// File: tb/tb_sda_kernel_ctrl_regs.sv
// Directed bench for sda_kernel_ctrl_regs: register access, action handshake,
// interrupt, busy-time write drops, channel back-pressure and async reset.
module tb_sda_kernel_ctrl_regs;
  localparam logic [63:0] P_RST = 64'hFEDC_BA98_7654_3210;
  localparam logic [31:0] A_CTRL = 32'h00, A_GIE = 32'h04, A_IER = 32'h08,
                          A_ISR = 32'h0C, A_PLO = 32'h10, A_PHI = 32'h14;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        go_0r, done_0a, interrupt;
  logic        go_0a = 1'b0, done_0r = 1'b0;
  logic [63:0] param_buf_base;

  int checks = 0, errors = 0;
  int cyc = 0, b_cyc = 0, go_rises = 0;
  logic go_prev = 1'b0;
  logic [1:0]  last_bresp, last_rresp;
  logic [31:0] last_rdata;

  sda_kernel_ctrl_regs #(.ADDR_WIDTH(6), .PARAM_RESET(P_RST)) dut (
    .clk(clk), .reset(rst_n),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .go_0r(go_0r), .go_0a(go_0a), .done_0r(done_0r), .done_0a(done_0a),
    .param_buf_base(param_buf_base), .interrupt(interrupt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (go_0r && !go_prev) go_rises++;
    go_prev = go_0r;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    logic aw_hs, w_hs;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 40) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      tick(); n++;
      if (aw_hs) awvalid = 1'b0;
      if (w_hs)  wvalid  = 1'b0;
    end
    while (!bvalid && n < 40) begin tick(); n++; end
    check("wr_bvalid", bvalid, 1'b1);
    awvalid = 1'b0; wvalid = 1'b0;
    b_cyc = cyc;
    last_bresp = bresp;
    tick();
  endtask

  task automatic axi_read(input logic [31:0] a);
    int n;
    logic ar_hs;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (arvalid && n < 40) begin
      ar_hs = arvalid && arready;
      tick(); n++;
      if (ar_hs) arvalid = 1'b0;
    end
    while (!rvalid && n < 40) begin tick(); n++; end
    check("rd_rvalid", rvalid, 1'b1);
    arvalid = 1'b0;
    last_rdata = rdata;
    last_rresp = rresp;
    tick();
  endtask

  task automatic write_ok(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    axi_write(a, d, s);
    check(tag, last_bresp, 2'b00);
  endtask

  task automatic read_expect(input string tag, input logic [31:0] a, input logic [31:0] exp);
    axi_read(a);
    check(tag, last_rdata, exp);
    check({tag, "_rresp"}, last_rresp, 2'b00);
  endtask

  task automatic wait_go();
    int n;
    n = 0;
    while (!go_0r && n < 30) begin tick(); n++; end
    check("go_seen", go_0r, 1'b1);
  endtask

  // Acks go after ack_dly cycles and completes the return-to-zero phase.
  task automatic go_handshake(input int ack_dly);
    wait_go();
    repeat (ack_dly) tick();
    check("go_held", go_0r, 1'b1);
    go_0a = 1'b1; tick();
    check("go_rtz", go_0r, 1'b0);
    go_0a = 1'b0; tick();
  endtask

  task automatic done_handshake(input int dly);
    int n;
    repeat (dly) tick();
    done_0r = 1'b1;
    n = 0;
    while (!done_0a && n < 30) begin tick(); n++; end
    check("done_ack", done_0a, 1'b1);
    done_0r = 1'b0; tick();
    check("done_ack_drop", done_0a, 1'b0);
  endtask

  initial begin
    logic hold_ok;
    int n;
    // Reset values
    #12;
    check("rst_awready", awready, 1'b0);
    check("rst_wready", wready, 1'b0);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_arready", arready, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_go", go_0r, 1'b0);
    check("rst_done_ack", done_0a, 1'b0);
    check("rst_irq", interrupt, 1'b0);
    check("rst_param", param_buf_base, P_RST);
    tick(); rst_n = 1'b1; tick();

    read_expect("ctrl_idle", A_CTRL, 32'h4);

    // PARAM full-word and byte-strobe writes
    write_ok("bresp_plo", A_PLO, 32'h89AB_CDEF, 4'hF);
    write_ok("bresp_phi", A_PHI, 32'h0123_4567, 4'hF);
    check("param_full", param_buf_base, 64'h0123_4567_89AB_CDEF);
    read_expect("rd_plo", A_PLO, 32'h89AB_CDEF);
    read_expect("rd_phi", A_PHI, 32'h0123_4567);
    write_ok("bresp_plo_b0", A_PLO, 32'h0000_00FF, 4'h1);
    check("param_byte0", param_buf_base, 64'h0123_4567_89AB_CDFF);

    // Interrupt enables
    write_ok("bresp_gie", A_GIE, 32'h1, 4'hF);
    write_ok("bresp_ier", A_IER, 32'h1, 4'hF);
    read_expect("rd_gie", A_GIE, 32'h1);

    // One full action with busy-time writes
    write_ok("bresp_start", A_CTRL, 32'h1, 4'hF);
    wait_go();
    check("start_latency", cyc - b_cyc, 2);
    go_handshake(3);
    read_expect("ctrl_busy", A_CTRL, 32'h1);
    write_ok("bresp_start_busy", A_CTRL, 32'h1, 4'hF);
    write_ok("bresp_plo_busy", A_PLO, 32'h0000_DEAD, 4'hF);
    check("param_busy", param_buf_base, 64'h0123_4567_89AB_CDFF);
    done_handshake(10);
    check("irq_done", interrupt, 1'b1);
    check("go_rises_one", go_rises, 1);
    read_expect("ctrl_done", A_CTRL, 32'h6);
    read_expect("ctrl_cleared", A_CTRL, 32'h4);
    read_expect("rd_isr_set", A_ISR, 32'h1);
    write_ok("bresp_isr", A_ISR, 32'h1, 4'hF);
    check("irq_w1c", interrupt, 1'b0);
    read_expect("rd_isr_clr", A_ISR, 32'h0);
    check("go_rises_still_one", go_rises, 1);

    // Action with GIE=0: ISR sets but interrupt stays low
    write_ok("bresp_gie0", A_GIE, 32'h0, 4'hF);
    write_ok("bresp_start2", A_CTRL, 32'h1, 4'hF);
    go_handshake(1);
    done_handshake(2);
    check("irq_gie0", interrupt, 1'b0);
    read_expect("rd_isr_gie0", A_ISR, 32'h1);
    write_ok("bresp_gie1", A_GIE, 32'h1, 4'hF);
    check("irq_gie_reen", interrupt, 1'b1);
    write_ok("bresp_isr2", A_ISR, 32'h1, 4'hF);
    check("irq_w1c2", interrupt, 1'b0);

    // W three cycles ahead of AW, then B back-pressure for 5 cycles
    bready = 1'b0;
    wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    check("wready_pulse", wready, 1'b1);
    tick(); wvalid = 1'b0;
    tick();
    awaddr = A_PHI; awvalid = 1'b1;
    tick();
    check("awready_pulse", awready, 1'b1);
    tick(); awvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    check("split_bvalid", bvalid, 1'b1);
    check("split_bresp", bresp, 2'b00);
    // A second write presented during the hold must not be accepted
    awaddr = A_GIE; awvalid = 1'b1; wdata = 32'h0; wvalid = 1'b1;
    hold_ok = 1'b1;
    repeat (5) begin
      tick();
      hold_ok = hold_ok && bvalid && !awready && !wready;
    end
    check("b_hold", hold_ok, 1'b1);
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    tick();
    check("b_release", bvalid, 1'b0);
    check("param_split", param_buf_base, 64'hCAFE_F00D_89AB_CDFF);
    read_expect("rd_gie_kept", A_GIE, 32'h1);
    read_expect("rd_unmapped", 32'h3C, 32'h0);
    read_expect("rd_alias", 32'h110, 32'h89AB_CDFF);

    // Asynchronous reset during GO_REQ
    write_ok("bresp_start3", A_CTRL, 32'h1, 4'hF);
    wait_go();
    #2 rst_n = 1'b0;
    #1;
    check("async_go_drop", go_0r, 1'b0);
    check("async_param", param_buf_base, P_RST);
    tick(); rst_n = 1'b1; tick();
    read_expect("ctrl_after_rst1", A_CTRL, 32'h4);
    check("param_after_rst1", param_buf_base, P_RST);

    // Asynchronous reset during DONE_ACK
    write_ok("bresp_start4", A_CTRL, 32'h1, 4'hF);
    go_handshake(0);
    done_0r = 1'b1;
    n = 0;
    while (!done_0a && n < 30) begin tick(); n++; end
    check("done_ack_pre_rst", done_0a, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_done_drop", done_0a, 1'b0);
    done_0r = 1'b0;
    tick(); rst_n = 1'b1; tick();
    read_expect("ctrl_after_rst2", A_CTRL, 32'h4);
    read_expect("gie_after_rst2", A_GIE, 32'h0);
    check("param_after_rst2", param_buf_base, P_RST);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sda_kernel_ctrl_regs.md
Name: sda_kernel_ctrl_regs

Overview:
- AXI-Lite control register slave that sequences one kernel action through its go/done handshake pair.
- Holds the param_buf_base pointer presented to the action and raises a done interrupt.
- Sits between the host-facing s_axi control port and the teak action toplevel's go_0r/go_0a/done_0r/done_0a and param_buf_base inputs.

Parameters:
- ADDR_WIDTH, 6, s_axi address bits decoded; upper bits are ignored.
- PARAM_RESET, 64'h0, reset value of param_buf_base.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset; clk is the only clock.
- s_axi_awaddr in 32, s_axi_awvalid in 1, s_axi_awready out 1  write address channel
- s_axi_wdata in 32, s_axi_wstrb in 4, s_axi_wvalid in 1, s_axi_wready out 1  write data channel
- s_axi_bresp out 2, s_axi_bvalid out 1, s_axi_bready in 1  write response channel
- s_axi_araddr in 32, s_axi_arvalid in 1, s_axi_arready out 1  read address channel
- s_axi_rdata out 32, s_axi_rresp out 2, s_axi_rvalid out 1, s_axi_rready in 1  read data channel
- go_0r out 1, go_0a in 1  action start request/ack, four-phase
- done_0r in 1, done_0a out 1  action completion request/ack, four-phase
- param_buf_base out 64  parameter buffer pointer to the action
- interrupt out 1  level interrupt = GIE & IER[0] & ISR[0]

Behaviour:
- Reset (reset low): all outputs 0 except param_buf_base=PARAM_RESET. The FSM goes to IDLE immediately, even mid-handshake. go_0r and done_0a drop asynchronously.
- Register map (byte address, bits [5:2] decoded):
  - 0x00 CTRL: b0 ap_start (W1S, reads 1 while FSM not IDLE); b1 ap_done (RO, clear-on-read); b2 ap_idle (RO, 1 in IDLE).
  - 0x04 GIE: b0.
  - 0x08 IER: b0.
  - 0x0C ISR: b0, W1C.
  - 0x10 PARAM_LO, 0x14 PARAM_HI: RW with byte strobes.
  - Other offsets read 0, writes are dropped. bresp/rresp are always 2'b00.
- Write channel:
  - AW and W are captured independently; each ready pulses 1 cycle after its valid is seen.
  - bvalid asserts the cycle after both are captured and holds until bready.
  - One outstanding write at a time; awready/wready stay 0 while bvalid is 1.
- Read channel:
  - arready pulses 1 cycle after arvalid.
  - rvalid asserts the next cycle with registered rdata and holds until rready.
  - No new read is accepted while rvalid is 1.
  - A CTRL read clears ap_done on the rvalid&rready cycle.
- Action FSM:
  - IDLE: a write of CTRL b0=1 moves to GO_REQ next cycle.
  - GO_REQ: go_0r=1; when go_0a=1, go to GO_RTZ.
  - GO_RTZ: go_0r=0; when go_0a=0, go to RUN.
  - RUN: when done_0r=1, go to DONE_ACK.
  - DONE_ACK: done_0a=1; when done_0r=0, set done_0a=0, set ap_done=1 and ISR[0]=1, go to IDLE.
- Write side effects:
  - ap_start writes outside IDLE are ignored.
  - PARAM_LO/HI writes outside IDLE are dropped (still OKAY), so param_buf_base is stable for the whole action.
- Simultaneous events:
  - ap_done set and CTRL clear-on-read in the same cycle: set wins.
  - ISR W1C and done set in the same cycle: set wins.
  - ap_start write in the same cycle the FSM enters IDLE is ignored; the host retries after observing ap_idle.
- Latency: CTRL start write accepted (bvalid) to go_0r=1 is 2 cycles.

Test Plan:
- Write PARAM_LO=0x89ABCDEF, PARAM_HI=0x01234567 with wstrb=4'hF -> param_buf_base=64'h0123456789ABCDEF; readback matches. Repeat with wstrb=4'h1, data 0xFF on LO -> only byte0 becomes 0xFF.
- Write CTRL=1; action model acks go after 3 cycles and raises done after 10 -> go_0r high until go_0a; done_0a follows done_0r. CTRL reads 0x4 before start, 0x1 while busy, 0x6 after completion, then 0x4 on the next read.
- GIE=1, IER=1, run one action -> interrupt=1 after completion; write ISR=1 -> interrupt=0 next cycle. With GIE=0, interrupt stays 0.
- While in RUN, write CTRL=1 and PARAM_LO=0xDEAD -> no second go_0r; param_buf_base unchanged; both bresp=00.
- Drive W 3 cycles before AW, then hold bready=0 for 5 cycles -> bvalid held 5 cycles; awready/wready remain 0 during the hold. Read 0x3C -> rdata=0, rresp=00.
- Assert reset low during GO_REQ and during DONE_ACK -> go_0r/done_0a drop without waiting for a clock edge; after release CTRL reads 0x4 and PARAM equals PARAM_RESET.
